// File: rtl/ts_channel_switch_ctrl.sv
// -----------------------------------------------------------------------------
// ts_channel_switch_ctrl
//
// Purpose:
//   Packet-aware channel selection controller for the 4-input MPEG-TS mux
//   that feeds the async FIFO (clk2 domain). Once per evaluation window it
//   ranks the four channels by their packet-loss increment and may request a
//   switch to the best one. Switches are only performed on 188-byte packet
//   boundaries, and every packet written to the FIFO starts with a sync byte.
//
// Ports:
//   clk2          in   1    main clock
//   rst           in   1    synchronous active-high reset
//   valid_in      in   4    per-channel byte valid
//   sync_in       in   4    per-channel sync-byte flag (qualified by valid_in)
//   err_count     in   128  four 32-bit cumulative loss counters, ch n at [32n+31:32n]
//   fifo_full     in   1    FIFO full flag (write side)
//   mux_ctrl      out  2    selected channel (registered)
//   w_en          out  1    FIFO write enable (combinational)
//   state_o       out  2    0 = ALIGN, 1 = RUN, 2 = DRAIN
//   switch_count  out  16   completed switches, saturating
//   drop_count    out  16   bytes lost to fifo_full, saturating
// -----------------------------------------------------------------------------
module ts_channel_switch_ctrl #(
  parameter int unsigned PKT_LEN     = 188,
  parameter int unsigned WINDOW      = 27000,
  parameter int unsigned HYST        = 2,
  parameter int unsigned HOLDOFF_WIN = 4
) (
  input  logic         clk2,
  input  logic         rst,
  input  logic [3:0]   valid_in,
  input  logic [3:0]   sync_in,
  input  logic [127:0] err_count,
  input  logic         fifo_full,
  output logic [1:0]   mux_ctrl,
  output logic         w_en,
  output logic [1:0]   state_o,
  output logic [15:0]  switch_count,
  output logic [15:0]  drop_count
);

  localparam int unsigned NCH    = 4;
  localparam int unsigned ERR_W  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned CUR_W  = IDX_W + 1;
  localparam int unsigned WIN_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int unsigned HOLD_W = (HOLDOFF_WIN > 0) ? $clog2(HOLDOFF_WIN + 1) : 1;

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [1:0]        mux_q, mux_d;
  logic [1:0]        target_q, target_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  sw_cnt_q, sw_cnt_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [ERR_W-1:0]  prev_q [NCH];

  // ---------------------------------------------------------------------------
  // Selected-channel byte tracking
  // ---------------------------------------------------------------------------
  logic             v;
  logic             y;
  logic [CUR_W-1:0] idx_inc;
  logic [CUR_W-1:0] cur;
  logic             pkt_end;

  assign v       = valid_in[mux_q];
  assign y       = sync_in[mux_q] & v;
  assign idx_inc = CUR_W'(idx_q) + CUR_W'(1);
  // Position of the byte presented this cycle within its packet.
  assign cur     = y ? '0 : idx_inc;
  assign pkt_end = v & ~y & (cur == CUR_W'(PKT_LEN - 1));

  // ---------------------------------------------------------------------------
  // Window counter
  // ---------------------------------------------------------------------------
  logic win_end;

  assign win_end = (win_q == WIN_W'(WINDOW - 1));
  assign win_d   = win_end ? '0 : (win_q + WIN_W'(1));

  // ---------------------------------------------------------------------------
  // Per-window loss ranking; modular subtraction absorbs counter wrap-around
  // ---------------------------------------------------------------------------
  logic [ERR_W-1:0] delta [NCH];
  logic [1:0]       best;

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      delta[n] = err_count[ERR_W*n +: ERR_W] - prev_q[n];
    end
    // Strict less-than keeps ties on the lowest index.
    best = 2'd0;
    for (int n = 1; n < NCH; n++) begin
      if (delta[n] < delta[best]) begin
        best = 2'(n);
      end
    end
  end

  logic [ERR_W-1:0] d_sel;
  logic [ERR_W-1:0] d_best;
  logic [ERR_W-1:0] margin;
  logic             sw_req;

  assign d_sel  = delta[mux_q];
  assign d_best = delta[best];
  assign margin = d_sel - d_best;
  // Decision only in RUN with holdoff expired and a clear advantage.
  assign sw_req = win_end
                & (state_q == ST_RUN)
                & (hold_q == '0)
                & (best != mux_q)
                & (d_sel > d_best)
                & (margin > ERR_W'(HYST));

  // ---------------------------------------------------------------------------
  // FSM next-state and write qualification
  // ---------------------------------------------------------------------------
  logic wr_raw;   // write enable before fifo_full gating
  logic sw_done;  // switch completes at the next edge

  always_comb begin
    state_d  = state_q;
    mux_d    = mux_q;
    target_d = target_q;
    wr_raw   = 1'b0;
    sw_done  = 1'b0;
    unique case (state_q)
      ST_ALIGN: begin
        // Only a sync byte may start a packet in the FIFO.
        wr_raw = y;
        if (y) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wr_raw = v;
        if (sw_req) begin
          target_d = best;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Finish the current packet; an early sync ends it without writing.
        wr_raw = v & ~y;
        if (pkt_end | y) begin
          sw_done = 1'b1;
          mux_d   = target_q;
          state_d = ST_ALIGN;
        end
      end
      default: begin
        state_d = ST_ALIGN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Index, holdoff and statistics next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d    = idx_q;
    hold_d   = hold_q;
    sw_cnt_d = sw_cnt_q;
    drop_d   = drop_q;

    // Index follows arriving bytes regardless of FIFO state.
    if (sw_done) begin
      idx_d = '0;
    end else if (y) begin
      idx_d = '0;
    end else if (v) begin
      if (idx_inc >= CUR_W'(PKT_LEN - 1)) begin
        idx_d = IDX_W'(PKT_LEN - 1);
      end else begin
        idx_d = idx_inc[IDX_W-1:0];
      end
    end

    if (sw_done) begin
      hold_d = HOLD_W'(HOLDOFF_WIN);
    end else if (win_end && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    if (sw_done && (sw_cnt_q != '1)) begin
      sw_cnt_d = sw_cnt_q + CNT_W'(1);
    end

    if (fifo_full && wr_raw && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q  <= ST_ALIGN;
      mux_q    <= '0;
      target_q <= '0;
      idx_q    <= '0;
      win_q    <= '0;
      hold_q   <= '0;
      sw_cnt_q <= '0;
      drop_q   <= '0;
      for (int n = 0; n < NCH; n++) begin
        prev_q[n] <= '0;
      end
    end else begin
      state_q  <= state_d;
      mux_q    <= mux_d;
      target_q <= target_d;
      idx_q    <= idx_d;
      win_q    <= win_d;
      hold_q   <= hold_d;
      sw_cnt_q <= sw_cnt_d;
      drop_q   <= drop_d;
      // Snapshot is taken every window, whatever the FSM state.
      if (win_end) begin
        for (int n = 0; n < NCH; n++) begin
          prev_q[n] <= err_count[ERR_W*n +: ERR_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mux_ctrl     = mux_q;
  assign state_o      = state_q;
  assign switch_count = sw_cnt_q;
  assign drop_count   = drop_q;
  assign w_en         = wr_raw & ~fifo_full;

endmodule

// File: tb/tb_ts_channel_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ts_channel_switch_ctrl
//
// Purpose:
//   Directed bench for ts_channel_switch_ctrl. All four channels stream
//   back-to-back packets in a common phase; loss counters are stepped by hand
//   between window ends and outputs are compared against hand-derived values.
//   A shorter window keeps the run brief.
// -----------------------------------------------------------------------------
module tb_ts_channel_switch_ctrl;

  localparam int unsigned PKT_LEN     = 188;
  localparam int unsigned WINDOW      = 500;
  localparam int unsigned HYST        = 2;
  localparam int unsigned HOLDOFF_WIN = 4;
  localparam int unsigned MID         = 400;

  logic         clk2 = 1'b0;
  logic         rst;
  logic [3:0]   valid_in;
  logic [3:0]   sync_in;
  logic [127:0] err_count;
  logic         fifo_full;
  logic [1:0]   mux_ctrl;
  logic         w_en;
  logic [1:0]   state_o;
  logic [15:0]  switch_count;
  logic [15:0]  drop_count;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  int unsigned pos     = 180;  // next byte position of the common stream
  int unsigned cur_pos = 0;    // position of the byte presented this cycle
  int unsigned wph     = 0;    // window phase of the current cycle
  logic        stream  = 1'b0;
  logic        full_req = 1'b0;
  logic [31:0] err [4];

  always #5 clk2 = ~clk2;

  ts_channel_switch_ctrl #(
    .PKT_LEN     (PKT_LEN),
    .WINDOW      (WINDOW),
    .HYST        (HYST),
    .HOLDOFF_WIN (HOLDOFF_WIN)
  ) dut (
    .clk2         (clk2),
    .rst          (rst),
    .valid_in     (valid_in),
    .sync_in      (sync_in),
    .err_count    (err_count),
    .fifo_full    (fifo_full),
    .mux_ctrl     (mux_ctrl),
    .w_en         (w_en),
    .state_o      (state_o),
    .switch_count (switch_count),
    .drop_count   (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and present the inputs for the new cycle.
  task automatic cyc();
    @(posedge clk2);
    #1;
    if (rst) wph = 0;
    else     wph = (wph + 1) % WINDOW;
    if (stream) begin
      cur_pos  = pos;
      valid_in = 4'hF;
      sync_in  = (pos == 0) ? 4'hF : 4'h0;
      pos      = (pos + 1) % PKT_LEN;
    end else begin
      valid_in = 4'h0;
      sync_in  = 4'h0;
    end
    fifo_full = full_req;
    err_count = {err[3], err[2], err[1], err[0]};
    #1;
  endtask

  task automatic run_to(input int unsigned ph);
    int unsigned n;
    n = 0;
    do begin
      cyc();
      n++;
    end while ((wph != ph) && (n < 2 * WINDOW));
  endtask

  // Run through the window end and check the resulting state.
  task automatic end_win(input string tag, input logic [1:0] exp_state, input logic [1:0] exp_mux);
    run_to(WINDOW - 1);
    cyc();
    chk({tag, "_state"}, 32'(state_o), 32'(exp_state));
    chk({tag, "_mux"}, 32'(mux_ctrl), 32'(exp_mux));
  endtask

  // Follow a DRAIN to completion and check the hand-over to the new channel.
  task automatic finish_drain(input string tag, input logic [1:0] exp_mux, input logic [15:0] exp_sw);
    int unsigned n;
    int unsigned last_pos;
    n = 0;
    last_pos = 0;
    while ((state_o == 2'd2) && (n < 2 * PKT_LEN)) begin
      chk({tag, "_drain_wen"}, 32'(w_en), 32'd1);
      last_pos = cur_pos;
      cyc();
      n++;
    end
    chk({tag, "_last_pos"}, last_pos, 32'(PKT_LEN - 1));
    chk({tag, "_align_state"}, 32'(state_o), 32'd0);
    chk({tag, "_new_mux"}, 32'(mux_ctrl), 32'(exp_mux));
    chk({tag, "_sync_wen"}, 32'(w_en), 32'd1);
    chk({tag, "_sw_cnt"}, 32'(switch_count), 32'(exp_sw));
    cyc();
    chk({tag, "_run_state"}, 32'(state_o), 32'd1);
  endtask

  initial begin
    for (int n = 0; n < 4; n++) err[n] = 32'd0;
    rst       = 1'b1;
    valid_in  = 4'h0;
    sync_in   = 4'h0;
    fifo_full = 1'b0;
    err_count = '0;

    // Reset state
    cyc(); cyc(); cyc();
    chk("rst_mux", 32'(mux_ctrl), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_sw_cnt", 32'(switch_count), 32'd0);
    chk("rst_drop_cnt", 32'(drop_count), 32'd0);
    chk("rst_wen", 32'(w_en), 32'd0);

    // ALIGN discards non-sync bytes, even while full, without counting drops
    rst = 1'b0;
    stream = 1'b1;
    full_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("align_discard_wen", 32'(w_en), 32'd0);
    end
    full_req = 1'b0;
    cyc();
    chk("align_sync_wen", 32'(w_en), 32'd1);
    chk("align_drop_cnt", 32'(drop_count), 32'd0);
    chk("align_state", 32'(state_o), 32'd0);
    cyc();
    chk("run_state", 32'(state_o), 32'd1);
    chk("run_wen", 32'(w_en), 32'd1);

    // Static counters: every ch0 byte written, no switch
    for (int i = 0; (i < int'(WINDOW)) && (wph != WINDOW - 1); i++) begin
      cyc();
      chk("run_wen_stream", 32'(w_en), 32'd1);
    end
    cyc();
    chk("static_state", 32'(state_o), 32'd1);
    chk("static_mux", 32'(mux_ctrl), 32'd0);
    chk("static_sw_cnt", 32'(switch_count), 32'd0);

    // ch2 clearly best -> drain ch0 packet, switch to ch2
    run_to(MID);
    err[0] += 32'd10; err[1] += 32'd5; err[2] += 32'd1; err[3] += 32'd5;
    end_win("sw1_req", 2'd2, 2'd0);
    finish_drain("sw1", 2'd2, 16'd1);

    // Holdoff blocks four window ends; ch1/ch3 tie -> ch1 wins on the fifth
    for (int w = 1; w <= 5; w++) begin
      run_to(MID);
      err[0] += 32'd5; err[2] += 32'd5;
      if (w < 5) end_win("hold_sw2", 2'd1, 2'd2);
      else       end_win("sw2_req", 2'd2, 2'd2);
    end
    finish_drain("sw2", 2'd1, 16'd2);

    // ch0 counter wraps: delta must be 3, making ch0 best (ch1 delta 6)
    for (int w = 1; w <= 3; w++) begin
      run_to(MID);
      end_win("hold_sw3", 2'd1, 2'd1);
    end
    run_to(MID);
    err[0] = 32'hFFFF_FFFE;
    end_win("wrap_pre", 2'd1, 2'd1);
    run_to(MID);
    err[0] = 32'h0000_0001; err[1] += 32'd6; err[2] += 32'd5; err[3] += 32'd5;
    end_win("wrap_req", 2'd2, 2'd1);
    finish_drain("sw3", 2'd0, 16'd3);

    // fifo_full for 10 cycles in RUN with continuous valid
    full_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("full_wen", 32'(w_en), 32'd0);
    end
    full_req = 1'b0;
    cyc();
    chk("full_drop_cnt", 32'(drop_count), 32'd10);
    chk("full_release_wen", 32'(w_en), 32'd1);
    chk("full_state", 32'(state_o), 32'd1);

    // Reach DRAIN again, then reset in the middle of it
    for (int w = 1; w <= 5; w++) begin
      run_to(MID);
      err[0] += 32'd10;
      if (w < 5) end_win("hold_sw4", 2'd1, 2'd0);
      else       end_win("sw4_req", 2'd2, 2'd0);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("drain_rst_mux", 32'(mux_ctrl), 32'd0);
    chk("drain_rst_state", 32'(state_o), 32'd0);
    chk("drain_rst_sw_cnt", 32'(switch_count), 32'd0);
    chk("drain_rst_drop_cnt", 32'(drop_count), 32'd0);
    for (int n = 0; (n < int'(2 * PKT_LEN)) && (cur_pos != 0); n++) begin
      chk("drain_rst_wen", 32'(w_en), 32'd0);
      cyc();
    end
    chk("drain_rst_sync_wen", 32'(w_en), 32'd1);
    cyc();
    chk("drain_rst_run", 32'(state_o), 32'd1);
    chk("drain_rst_run_mux", 32'(mux_ctrl), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
